layer_sequencer: RTL
====================

# layer_sequencer

Sequences a stack of `NUM_LAYERS` ternary down-projection layers through one inference or training step. It issues single-cycle forward-propagation pulses to layers 0..L-1 in order, waiting for each layer's done pulse. In training mode it then issues backward-propagation pulses to layers L-1..0. It sits between the top-level host/FSM and the layer instances, and replaces ad-hoc hardwired prop/done chaining.

## Interface
Parameters:
- `NUM_LAYERS`, default 4: number of sequenced layers, ≥1.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles to wait for any single layer done pulse, ≥2.

Ports:
- `clk_in` input 1: single clock, all logic on rising edge.
- `rst_in` input 1: synchronous, active-low reset (sampled on `clk_in`; 0 = reset).
- `start` input 1: request one step; sampled only in IDLE.
- `train` input 1: captured with `start`; 1 = forward then backward, 0 = forward only.
- `abort` input 1: cancel the current step.
- `clear_err` input 1: leave ERR.
- `fd_prop_done` input NUM_LAYERS: per-layer forward done pulses.
- `bk_prop_done` input NUM_LAYERS: per-layer backward done pulses.
- `fd_prop` output NUM_LAYERS: one-hot, single-cycle forward start pulses.
- `bk_prop` output NUM_LAYERS: one-hot, single-cycle backward start pulses.
- `busy` output 1: high in any state except IDLE and ERR.
- `done` output 1: one-cycle pulse on successful step completion.
- `error` output 1: high while in ERR (timeout).
- `layer_idx` output $clog2(NUM_LAYERS) (min 1): layer currently issued or awaited.
- `err_layer` output $clog2(NUM_LAYERS) (min 1): layer that timed out; held until the next timeout.

## Operation
- States: IDLE, FWD_ISSUE, FWD_WAIT, BWD_ISSUE, BWD_WAIT, DONE, ERR.
- IDLE:
  - `start`=1 → FWD_ISSUE; `layer_idx`←0; `train` latched into `train_q`.
  - `start` is ignored in every other state.
- FWD_ISSUE:
  - Drive `fd_prop[layer_idx]`=1 for exactly one cycle.
  - → FWD_WAIT; watchdog cleared.
- FWD_WAIT:
  - On `fd_prop_done[layer_idx]`=1:
    - If `layer_idx`<L-1: `layer_idx`++ and → FWD_ISSUE.
    - Else if `train_q`: `layer_idx`←L-1 and → BWD_ISSUE.
    - Else → DONE.
  - Done bits of other layers are ignored.
- BWD_ISSUE / BWD_WAIT:
  - Mirror of the forward states, using `bk_prop` and `bk_prop_done`.
  - `layer_idx` decrements; after layer 0 completes → DONE.
- DONE: `done`=1 for one cycle, then → IDLE.
- Timeout:
  - The watchdog counts cycles spent in a WAIT state.
  - When the count reaches TIMEOUT_CYCLES with no matching done pulse: → ERR, with `err_layer`←`layer_idx`.
  - A done pulse arriving in the same cycle the count reaches the limit wins; there is no error in that case.
- ERR:
  - No prop pulses are issued; `error`=1.
  - `clear_err`=1 → IDLE.
- `abort`=1 in any state except IDLE or ERR:
  - → IDLE next cycle; no `done` pulse; any prop pulse in that cycle is suppressed.
  - `abort` has priority over done pulses and timeout.
- Late done pulses arriving in IDLE or ERR are ignored.

## Timing
- Reset values: state IDLE; `fd_prop`=0, `bk_prop`=0, `busy`=0, `done`=0, `error`=0, `layer_idx`=0, `err_layer`=0, watchdog=0, `train_q`=0.
- Reset is applied mid-operation the same way; in-flight layers are not notified.
- All outputs are registered.
- `start` sampled at edge 0 → `fd_prop[0]` high in cycle 1.
- A done pulse sampled in cycle c → the next prop pulse is in cycle c+1, or `done` in cycle c+1.
- Throughput: per layer, 1 issue cycle plus d wait cycles, where d = cycles from prop to done (d ≥ 1).
- `busy` rises in the cycle after `start` and falls in the cycle after `done`.
- The earliest next `start` is accepted in the cycle after `done`.

## Structure
- Package `layer_seq_pkg`: state enum `seq_state_t`; helper function `idx_w(n)` = max(1, $clog2(n)).
- Sub-module `seq_watchdog`: clearable, enable-gated counter with a `expired` flag at TIMEOUT_CYCLES. It is instantiated once.
- One-hot prop vectors are decoded from `layer_idx` gated by the ISSUE state.

## Test plan
- **Inference, L=3, d=2:** `start`=1, `train`=0 at cycle 0 → `fd_prop` one-hot at cycles 1, 4, 7; `done` at cycle 10; `bk_prop` never asserted.
- **Training, L=3, d=2:** → `bk_prop[2]`, `bk_prop[1]`, `bk_prop[0]` at cycles 10, 13, 16; `done` at cycle 19; `layer_idx` sequence 0,1,2,2,1,0.
- **Timeout, TIMEOUT_CYCLES=8:** layer 1 never answers → `error`=1 eight cycles after its FWD_WAIT entry, with `err_layer`=1 and `busy`=0. Then `clear_err` → IDLE, and a subsequent `start` works.
- **Abort during FWD_WAIT of layer 1** → IDLE next cycle; no `done`. A stray `fd_prop_done[1]` two cycles later is ignored; the next `start` begins at layer 0.
- **Robustness:**
  - `start` pulsed while busy → no effect.
  - Wrong-layer done (`fd_prop_done[2]` while awaiting 0) → no advance.
  - Done coincident with watchdog expiry → advance, no error.
- **Reset:** `rst_in`=0 for one cycle during BWD_WAIT → all outputs at reset values the next cycle. NUM_LAYERS=1 sanity: forward+backward completes with `layer_idx` constantly 0.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared types for the layer sequencer:
// FSM state encoding and index-width helper.
package layer_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD_ISSUE,
    S_FWD_WAIT,
    S_BWD_ISSUE,
    S_BWD_WAIT,
    S_DONE,
    S_ERR
  } seq_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer wait watchdog: counts enabled cycles,
// flags expiry on the TIMEOUT_CYCLES-th one.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt = waited cycles before the current one; saturates
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
// Drives forward (and optionally backward) prop pulses
// through a layer stack, one layer at a time.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_LAYERS     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic                          train,
  input  logic                          abort,
  input  logic                          clear_err,
  input  logic [NUM_LAYERS-1:0]         fd_prop_done,
  input  logic [NUM_LAYERS-1:0]         bk_prop_done,
  output logic [NUM_LAYERS-1:0]         fd_prop,
  output logic [NUM_LAYERS-1:0]         bk_prop,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [idx_w(NUM_LAYERS)-1:0]  layer_idx,
  output logic [idx_w(NUM_LAYERS)-1:0]  err_layer
);

  localparam int IW = idx_w(NUM_LAYERS);
  localparam logic [IW-1:0] LAST = IW'(NUM_LAYERS - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  seq_state_t state;
  logic       train_q;
  logic       in_wait;
  logic       wd_expired;
  logic       fwd_hit;
  logic       bwd_hit;
  logic       kill;

  function automatic logic [NUM_LAYERS-1:0] sel(
    input logic [IW-1:0] i
  );
    return NUM_LAYERS'(1) << i;
  endfunction

  assign in_wait = (state == S_FWD_WAIT) ||
                   (state == S_BWD_WAIT);
  assign fwd_hit = fd_prop_done[layer_idx];
  assign bwd_hit = bk_prop_done[layer_idx];
  assign kill    = abort &&
                   (state != S_IDLE) &&
                   (state != S_ERR);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (!in_wait),
    .en     (in_wait),
    .expired(wd_expired)
  );

  // Sequencer FSM; outputs registered alongside next state
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= S_IDLE;
      train_q   <= 1'b0;
      fd_prop   <= '0;
      bk_prop   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      layer_idx <= '0;
      err_layer <= '0;
    end else begin
      fd_prop <= '0;
      bk_prop <= '0;
      done    <= 1'b0;
      if (kill) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_FWD_ISSUE;
              layer_idx <= '0;
              train_q   <= train;
              fd_prop   <= sel('0);
              busy      <= 1'b1;
            end
          end
          S_FWD_ISSUE: begin
            state <= S_FWD_WAIT;
          end
          S_FWD_WAIT: begin
            if (fwd_hit) begin
              if (layer_idx != LAST) begin
                state     <= S_FWD_ISSUE;
                layer_idx <= layer_idx + ONE;
                fd_prop   <= sel(layer_idx + ONE);
              end else if (train_q) begin
                state     <= S_BWD_ISSUE;
                layer_idx <= LAST;
                bk_prop   <= sel(LAST);
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else if (wd_expired) begin
              state     <= S_ERR;
              err_layer <= layer_idx;
              error     <= 1'b1;
              busy      <= 1'b0;
            end
          end
          S_BWD_ISSUE: begin
            state <= S_BWD_WAIT;
          end
          S_BWD_WAIT: begin
            if (bwd_hit) begin
              if (layer_idx != '0) begin
                state     <= S_BWD_ISSUE;
                layer_idx <= layer_idx - ONE;
                bk_prop   <= sel(layer_idx - ONE);
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else if (wd_expired) begin
              state     <= S_ERR;
              err_layer <= layer_idx;
              error     <= 1'b1;
              busy      <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          S_ERR: begin
            if (clear_err) begin
              state <= S_IDLE;
              error <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            error <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
